// File: rtl/ldl_round_mux.sv
// Two-entry skid FIFO between a round-robin arbiter and a single downstream port.
// Optional grant-consistency checker enabled by defining LDL_ROUND_MUX_GNT_CHK_EN.
module ldl_round_mux #(
    parameter int WIDTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_arb_ack,
    input  logic [$clog2(WIDTH)-1:0]   i_arb_bin,
    input  logic [WIDTH-1:0]           i_arb_hot,
    input  logic [WIDTH*DATA_W-1:0]    i_req_data,
    output logic [WIDTH-1:0]           o_gnt_done,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [DATA_W-1:0]          o_out_data,
    output logic [$clog2(WIDTH)-1:0]   o_out_src,
    output logic [15:0]                o_drop_cnt,
    output logic                       o_err
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic [IDX_W-1:0]  r_src0;
    logic [IDX_W-1:0]  r_src1;
    logic [WIDTH-1:0]  r_gnt;
    logic [15:0]       r_drop;

    logic              w_valid;
    logic              w_pop;
    logic              w_space;
    logic              w_push;
    logic              w_binOk;
    logic [DATA_W-1:0] w_pushData;

    // Range check and payload select share one loop so out-of-range indices never slice.
    always_comb begin
        w_binOk    = 1'b0;
        w_pushData = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_arb_bin == IDX_W'(i)) begin
                w_binOk    = 1'b1;
                w_pushData = i_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid && i_out_ready;
    assign w_space = (r_count < 2'd2) || w_pop;
    assign w_push  = i_arb_ack && w_space && w_binOk;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_src0  <= '0;
            r_src1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= w_pushData;
                        r_src0  <= i_arb_bin;
                    end else begin
                        r_data1 <= w_pushData;
                        r_src1  <= i_arb_bin;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_src0  <= r_src1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // With one entry the new one becomes head; with two it queues behind entry 1.
                    if (r_count == 2'd1) begin
                        r_data0 <= w_pushData;
                        r_src0  <= i_arb_bin;
                    end else begin
                        r_data0 <= r_data1;
                        r_src0  <= r_src1;
                        r_data1 <= w_pushData;
                        r_src1  <= i_arb_bin;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gnt  <= '0;
            r_drop <= 16'd0;
        end else begin
            r_gnt <= w_push ? (WIDTH'(1) << i_arb_bin) : '0;
            if (i_arb_ack && w_binOk && !w_space && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

`ifdef LDL_ROUND_MUX_GNT_CHK_EN
    logic r_err;
    logic w_hotBad;

    assign w_hotBad = i_arb_ack && (!w_binOk || (i_arb_hot != (WIDTH'(1) << i_arb_bin)));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_hotBad) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_hot;
    assign w_unused_hot = ^i_arb_hot;
    assign o_err        = 1'b0;
`endif

    assign o_gnt_done  = r_gnt;
    assign o_out_valid = w_valid;
    assign o_out_data  = i_rst_n ? r_data0 : '0;
    assign o_out_src   = i_rst_n ? r_src0 : '0;
    assign o_drop_cnt  = r_drop;

endmodule

// File: tb/tb_ldl_round_mux.sv
// Self-checking bench for ldl_round_mux: directed vector table, hand sequences,
// drop-counter saturation and randomized traffic against a queue-based model.
module tb_ldl_round_mux;

    localparam logic [63:0] PATTERN = 64'hF7E6D5C4B3A59180;

`ifdef LDL_ROUND_MUX_GNT_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rstN;
    logic        arbAck;
    logic [2:0]  arbBin;
    logic [7:0]  arbHot;
    logic [63:0] reqData;
    logic [7:0]  gntDone;
    logic        outValid;
    logic        outReady;
    logic [7:0]  outData;
    logic [2:0]  outSrc;
    logic [15:0] dropCnt;
    logic        err;

    int nChecks = 0;
    int nFails  = 0;

    ldl_round_mux #(.WIDTH(8), .DATA_W(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_arb_ack  (arbAck),
        .i_arb_bin  (arbBin),
        .i_arb_hot  (arbHot),
        .i_req_data (reqData),
        .o_gnt_done (gntDone),
        .o_out_valid(outValid),
        .i_out_ready(outReady),
        .o_out_data (outData),
        .o_out_src  (outSrc),
        .o_drop_cnt (dropCnt),
        .o_err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          rstn;
        bit          ack;
        logic [2:0]  bin;
        logic [7:0]  hot;
        bit          ready;
        bit          eValid;
        logic [7:0]  eData;
        logic [2:0]  eSrc;
        logic [7:0]  eGnt;
        logic [15:0] eDrop;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] src;
    } entry_t;

    entry_t      mQ[$];
    logic [7:0]  mGnt;
    logic [15:0] mDrop;
    bit          mErr;

    task automatic applyStimulus(input bit rstn, input bit ack, input logic [2:0] bin,
                                 input logic [7:0] hot, input logic [63:0] data, input bit ready);
        rstN     = rstn;
        arbAck   = ack;
        arbBin   = bin;
        arbHot   = hot;
        reqData  = data;
        outReady = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference behaviour: a bounded queue of depth two evaluated once per clock edge.
    task automatic modelStep();
        bit pop;
        bit space;
        bit push;
        entry_t e;
        if (!rstN) begin
            mQ.delete();
            mGnt  = 8'h00;
            mDrop = 16'd0;
            mErr  = 1'b0;
        end else begin
            pop   = (mQ.size() != 0) && outReady;
            space = (mQ.size() < 2) || pop;
            push  = arbAck && space;
            if (CHK && arbAck && (arbHot != (8'h01 << arbBin))) mErr = 1'b1;
            if (pop) void'(mQ.pop_front());
            if (push) begin
                e.data = reqData[int'(arbBin)*8 +: 8];
                e.src  = arbBin;
                mQ.push_back(e);
            end
            mGnt = push ? (8'h01 << arbBin) : 8'h00;
            if (arbAck && !space && mDrop != 16'hFFFF) mDrop = mDrop + 16'd1;
        end
    endtask

    task automatic compareModel();
        checkOutput("rnd_valid", 32'(outValid), 32'(mQ.size() != 0));
        checkOutput("rnd_gnt", 32'(gntDone), 32'(mGnt));
        checkOutput("rnd_drop", 32'(dropCnt), 32'(mDrop));
        checkOutput("rnd_err", 32'(err), 32'(mErr));
        if (mQ.size() != 0) begin
            checkOutput("rnd_data", 32'(outData), 32'(mQ[0].data));
            checkOutput("rnd_src", 32'(outSrc), 32'(mQ[0].src));
        end else if (!rstN) begin
            checkOutput("rnd_data_rst", 32'(outData), 32'd0);
            checkOutput("rnd_src_rst", 32'(outSrc), 32'd0);
        end
    endtask

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{0, 0, 3'd0, 8'h00, 0, 0, 8'h00, 3'd0, 8'h00, 16'd0};
        vecs[1]  = '{0, 1, 3'd2, 8'h04, 1, 0, 8'h00, 3'd0, 8'h00, 16'd0};
        vecs[2]  = '{1, 1, 3'd2, 8'h04, 1, 1, 8'hA5, 3'd2, 8'h04, 16'd0};
        vecs[3]  = '{1, 0, 3'd0, 8'h00, 1, 0, 8'h00, 3'd0, 8'h00, 16'd0};
        vecs[4]  = '{1, 1, 3'd0, 8'h01, 0, 1, 8'h80, 3'd0, 8'h01, 16'd0};
        vecs[5]  = '{1, 1, 3'd5, 8'h20, 0, 1, 8'h80, 3'd0, 8'h20, 16'd0};
        vecs[6]  = '{1, 1, 3'd7, 8'h80, 0, 1, 8'h80, 3'd0, 8'h00, 16'd1};
        vecs[7]  = '{1, 0, 3'd0, 8'h00, 1, 1, 8'hD5, 3'd5, 8'h00, 16'd1};
        vecs[8]  = '{1, 0, 3'd0, 8'h00, 1, 0, 8'h00, 3'd0, 8'h00, 16'd1};
        vecs[9]  = '{1, 1, 3'd1, 8'h02, 0, 1, 8'h91, 3'd1, 8'h02, 16'd1};
        vecs[10] = '{1, 1, 3'd4, 8'h10, 0, 1, 8'h91, 3'd1, 8'h10, 16'd1};
        vecs[11] = '{1, 1, 3'd3, 8'h08, 1, 1, 8'hC4, 3'd4, 8'h08, 16'd1};
        vecs[12] = '{1, 0, 3'd0, 8'h00, 1, 1, 8'hB3, 3'd3, 8'h00, 16'd1};
        vecs[13] = '{1, 0, 3'd0, 8'h00, 0, 1, 8'hB3, 3'd3, 8'h00, 16'd1};
        vecs[14] = '{1, 1, 3'd6, 8'h40, 0, 1, 8'hB3, 3'd3, 8'h40, 16'd1};
        vecs[15] = '{0, 0, 3'd0, 8'h00, 0, 0, 8'h00, 3'd0, 8'h00, 16'd0};
        vecs[16] = '{1, 0, 3'd0, 8'h00, 1, 0, 8'h00, 3'd0, 8'h00, 16'd0};

        rstN = 1'b0; arbAck = 1'b0; arbBin = '0; arbHot = '0; reqData = '0; outReady = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].ack, vecs[i].bin, vecs[i].hot, PATTERN, vecs[i].ready);
            checkOutput($sformatf("vec%0d_valid", i), 32'(outValid), 32'(vecs[i].eValid));
            checkOutput($sformatf("vec%0d_gnt", i), 32'(gntDone), 32'(vecs[i].eGnt));
            checkOutput($sformatf("vec%0d_drop", i), 32'(dropCnt), 32'(vecs[i].eDrop));
            checkOutput($sformatf("vec%0d_err", i), 32'(err), 32'd0);
            if (vecs[i].eValid) begin
                checkOutput($sformatf("vec%0d_data", i), 32'(outData), 32'(vecs[i].eData));
                checkOutput($sformatf("vec%0d_src", i), 32'(outSrc), 32'(vecs[i].eSrc));
            end
            if (!vecs[i].rstn) begin
                checkOutput($sformatf("vec%0d_data_rst", i), 32'(outData), 32'd0);
                checkOutput($sformatf("vec%0d_src_rst", i), 32'(outSrc), 32'd0);
            end
        end

        $display("[TB] inconsistent grant sequence");
        applyStimulus(1, 1, 3'd1, 8'h04, PATTERN, 1);
        checkOutput("badhot_gnt", 32'(gntDone), 32'h02);
        checkOutput("badhot_data", 32'(outData), 32'h91);
        checkOutput("badhot_err", 32'(err), 32'(CHK));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 3'd0, 8'h00, PATTERN, 1);
            checkOutput("badhot_err_hold", 32'(err), 32'(CHK));
        end
        applyStimulus(0, 0, 3'd0, 8'h00, PATTERN, 1);
        checkOutput("badhot_err_rst", 32'(err), 32'd0);

        $display("[TB] drop counter saturation");
        applyStimulus(1, 1, 3'd1, 8'h02, PATTERN, 0);
        applyStimulus(1, 1, 3'd1, 8'h02, PATTERN, 0);
        checkOutput("sat_fill_drop", 32'(dropCnt), 32'd0);
        for (int i = 0; i < 65534; i++) applyStimulus(1, 1, 3'd1, 8'h02, PATTERN, 0);
        checkOutput("sat_almost", 32'(dropCnt), 32'hFFFE);
        applyStimulus(1, 1, 3'd1, 8'h02, PATTERN, 0);
        checkOutput("sat_reach", 32'(dropCnt), 32'hFFFF);
        for (int i = 0; i < 4465; i++) applyStimulus(1, 1, 3'd1, 8'h02, PATTERN, 0);
        checkOutput("sat_hold", 32'(dropCnt), 32'hFFFF);
        checkOutput("sat_gnt", 32'(gntDone), 32'h00);
        checkOutput("sat_head", 32'(outData), 32'h91);

        $display("[TB] randomized traffic");
        applyStimulus(0, 0, 3'd0, 8'h00, 64'd0, 0);
        modelStep();
        compareModel();
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] b;
            logic [7:0] h;
            b = 3'($urandom_range(0, 7));
            h = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (8'h01 << b);
            applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 2) != 0, b, h,
                          {$urandom, $urandom}, $urandom_range(0, 1) == 1);
            modelStep();
            compareModel();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
